operand_entry: RTL

- Input-side counterpart of the calculator display path: conditions the raw switch and push-button pins and sequences operand entry for the ALU.
- Synchronises and debounces the active-low keys and captures the inverted 4-bit switch value into operand A, then operand B.
- Presents both operands to the ALU through a valid/ack handshake.
- Drives the 3-bit active-low stage LEDs.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/operand_entry_if.sv | 23 ++
 rtl/operand_entry_key_debounce.sv | 51 +++++
 rtl/operand_entry.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry path.
package calc_pkg;

  localparam int unsigned NUM_W = 4;
  localparam int unsigned KEY_W = 2;
  localparam int unsigned LED_W = 3;

  localparam int unsigned KEY_ENTER = 1;
  localparam int unsigned KEY_CLEAR = 0;

  localparam logic [LED_W-1:0] LED_OPA   = 3'b110;
  localparam logic [LED_W-1:0] LED_OPB   = 3'b101;
  localparam logic [LED_W-1:0] LED_READY = 3'b011;

  typedef enum logic [1:0] {
    S_OPA   = 2'd0,
    S_OPB   = 2'd1,
    S_READY = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_W-1:0] a;
    logic [NUM_W-1:0] b;
  } operands_t;

  // Active-low stage LED pattern for a given entry state.
  function automatic logic [LED_W-1:0] led_for(input state_t s);
    case (s)
      S_OPB:   led_for = LED_OPB;
      S_READY: led_for = LED_READY;
      default: led_for = LED_OPA;
    endcase
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Pin and ALU-handshake bundle for operand_entry; master is the entry block.
interface operand_entry_if;
  import calc_pkg::*;

  logic [NUM_W-1:0] in_number;
  logic [KEY_W-1:0] key;
  logic [NUM_W-1:0] op_a;
  logic [NUM_W-1:0] op_b;
  logic             op_valid;
  logic             op_ack;
  logic [NUM_W-1:0] live_value;
  logic [LED_W-1:0] led;

  modport master (
    input  in_number, key, op_ack,
    output op_a, op_b, op_valid, live_value, led
  );

  modport slave (
    output in_number, key, op_ack,
    input  op_a, op_b, op_valid, live_value, led
  );
endinterface

// File: rtl/operand_entry_key_debounce.sv
// key_debounce: synchroniser, stability counter and press pulse for one
// active-low key. Released level is 1; only a 1->0 accepted flip pulses.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter only advances while the synced level disagrees; it never exceeds DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      press  <= 1'b0;
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_q <= synced;
        cnt_q   <= '0;
        press   <= ~synced;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry: debounced ENTER/CLEAR keys capture operands A then B for the ALU.
// Optional S_OPB idle timeout enabled by defining OPERAND_ENTRY_TIMEOUT_EN.
module operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_entry_if.master       bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [NUM_W-1:0] num_sync_q [SYNC_STAGES];
  logic [NUM_W-1:0] live_q;
  logic             enter_press;
  logic             clear_press;
  logic             tmo_hit_c;

  state_t           state_q, state_d;
  operands_t        ops_q, ops_d;
  logic             valid_q, valid_d;
  logic [LED_W-1:0] led_q;

  // Switch synchroniser; released (all ones) reads as live value 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) num_sync_q[i] <= '1;
      live_q <= '0;
    end else begin
      num_sync_q[0] <= bus.in_number;
      for (int i = 1; i < int'(SYNC_STAGES); i++) num_sync_q[i] <= num_sync_q[i-1];
      live_q <= ~num_sync_q[SYNC_STAGES-1];
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_enter (
    .clk   (clk),
    .rst   (rst),
    .pin   (bus.key[KEY_ENTER]),
    .press (enter_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .pin   (bus.key[KEY_CLEAR]),
    .press (clear_press)
  );

`ifdef OPERAND_ENTRY_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Idle counter lives only in S_OPB, so it is already zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q != S_OPB || enter_press || clear_press) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (state_q == S_OPB) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OPA;
      ops_q   <= '0;
      valid_q <= 1'b0;
      led_q   <= LED_OPA;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      valid_q <= valid_d;
      led_q   <= led_for(state_d);
    end
  end

  // CLEAR outranks ENTER, op_ack and timeout.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    valid_d = valid_q;
    if (clear_press) begin
      state_d = S_OPA;
      ops_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_OPA: begin
          if (enter_press) begin
            ops_d.a = live_q;
            state_d = S_OPB;
          end
        end
        S_OPB: begin
          if (enter_press) begin
            ops_d.b = live_q;
            valid_d = 1'b1;
            state_d = S_READY;
          end else if (tmo_hit_c) begin
            ops_d.a = '0;
            state_d = S_OPA;
          end
        end
        S_READY: begin
          if (bus.op_ack) begin
            valid_d = 1'b0;
            state_d = S_OPA;
          end
        end
        default: begin
          state_d = S_OPA;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.op_a       = ops_q.a;
  assign bus.op_b       = ops_q.b;
  assign bus.op_valid   = valid_q;
  assign bus.live_value = live_q;
  assign bus.led        = led_q;

endmodule
